// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store port: size codes, FSM states,
// and lane-count arithmetic derived from the memory word width.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int log2_bytes(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake plus memory bus, bundled for the unit.
// slave is the unit's view; master is the core/memory environment's view.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_we_i;
    logic [1:0]              req_size_i;
    logic                    req_unsigned_i;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [DATA_WIDTH-1:0]   req_wdata_i;
    logic                    rsp_valid_o;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    logic                    mem_valid_o;
    logic                    mem_ready_i;
    logic                    mem_we_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replicate + byte enables, load extract + extend.
// Bit-level loops keep it width-generic for 32- and 64-bit words.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                          size,
    input  logic [log2_bytes(DATA_WIDTH)-1:0]   off,
    input  logic                                uns,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [DATA_WIDTH-1:0]               rdata,
    output logic [bytes_of(DATA_WIDTH)-1:0]     be,
    output logic [DATA_WIDTH-1:0]               wrep,
    output logic [DATA_WIDTH-1:0]               rext
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int IW    = $clog2(DATA_WIDTH);

    always_comb begin
        int nb;
        int o;
        logic [DATA_WIDTH-1:0] shifted;
        nb = 1 << size;
        // Oversized requests are rejected upstream; clamp keeps indices in range.
        if (nb > BYTES) nb = BYTES;
        o       = int'(off);
        shifted = rdata >> (8 * o);
        be      = '0;
        wrep    = '0;
        rext    = '0;
        for (int i = 0; i < BYTES; i++) be[i] = (i >= o) && (i < o + nb);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            wrep[i] = wdata[IW'(i % (8 * nb))];
            rext[i] = (i < 8 * nb) ? shifted[i] : (~uns & shifted[IW'(8 * nb - 1)]);
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store port: one bus request per core access with valid/ready handshakes,
// misalignment rejection and a bounded wait for the memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int LB    = log2_bytes(DATA_WIDTH);
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                state;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [LB-1:0]         r_off;
    logic [CW-1:0]         cnt;
    logic                  rsp_valid, rsp_err, mem_valid, mem_we;
    logic [DATA_WIDTH-1:0] rsp_rdata, mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BYTES-1:0]      mem_be;

    logic                  idle, legal, tmo;
    logic [1:0]            a_size;
    logic [LB-1:0]         a_off;
    logic                  a_uns;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] wrep, rext;

    // The single aligner sees the live request while idle (store path) and the
    // captured request otherwise (load extraction).
    assign idle   = (state == IDLE);
    assign a_size = idle ? bus.req_size_i : r_size;
    assign a_off  = idle ? bus.req_addr_i[LB-1:0] : r_off;
    assign a_uns  = idle ? bus.req_unsigned_i : r_uns;
    assign tmo    = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size  (a_size),
        .off   (a_off),
        .uns   (a_uns),
        .wdata (bus.req_wdata_i),
        .rdata (bus.mem_rdata_i),
        .be    (be),
        .wrep  (wrep),
        .rext  (rext)
    );

    always_comb begin
        legal = 1'b0;
        case (size_e'(bus.req_size_i))
            SZ_B:    legal = 1'b1;
            SZ_H:    legal = ~bus.req_addr_i[0];
            SZ_W:    legal = (bus.req_addr_i[1:0] == 2'b00);
            SZ_D:    legal = (DATA_WIDTH == 64) && (bus.req_addr_i[2:0] == 3'b000);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_off     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid_i) begin
                    r_size    <= bus.req_size_i;
                    r_uns     <= bus.req_unsigned_i;
                    r_off     <= bus.req_addr_i[LB-1:0];
                    cnt       <= '0;
                    mem_we    <= bus.req_we_i;
                    mem_addr  <= bus.req_addr_i & ~ADDR_WIDTH'(BYTES - 1);
                    mem_be    <= be;
                    mem_wdata <= wrep;
                    if (legal) begin
                        mem_valid <= 1'b1;
                        state     <= BUS;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                BUS: begin
                    // Ready takes priority over an expiring timeout in the same cycle.
                    if (bus.mem_ready_i) begin
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= mem_we ? '0 : rext;
                        state     <= RESP;
                    end else if (tmo) begin
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = idle && !reset;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_wdata_o = mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (32-bit word, TIMEOUT = 4): directed vectors plus
// randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          ready_ok;
        int          nbus;
        int          lat;
        bit          stable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    // Drives one access from an idle cycle and plays the memory, raising ready
    // in BUS cycle number `delay` (negative = never). Latency counts from accept.
    task automatic run_acc(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, output obs_t o);
        o = '{default: 0};
        o.lat    = -1;
        o.stable = 1'b1;
        @(posedge clk); #1;
        o.ready_ok           = bus.req_ready_o && !bus.rsp_valid_o;
        bus.req_valid_i      = 1'b1;
        bus.req_we_i         = we;
        bus.req_size_i       = size;
        bus.req_unsigned_i   = uns;
        bus.req_addr_i       = addr;
        bus.req_wdata_i      = wdata;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.mem_ready_i = 1'b0;
            bus.mem_rdata_i = $urandom;
            if (bus.rsp_valid_o) begin
                o.lat   = c;
                o.err   = bus.rsp_err_o;
                o.rdata = bus.rsp_rdata_o;
                break;
            end
            if (bus.mem_valid_o) begin
                if (o.nbus == 0) begin
                    o.addr  = bus.mem_addr_o;
                    o.be    = bus.mem_be_o;
                    o.wdata = bus.mem_wdata_o;
                    o.we    = bus.mem_we_o;
                end else if ({o.addr, o.be, o.wdata, o.we} !==
                             {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_we_o}) begin
                    o.stable = 1'b0;
                end
                if (o.nbus == delay) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = rdata;
                end
                o.nbus++;
            end
            @(posedge clk); #1;
        end
        bus.mem_ready_i = 1'b0;
    endtask

    // Reference: expected bus view and response from the access rules alone.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int delay, output obs_t e);
        int     nb, off;
        bit     legal;
        longint mask, v, pat;
        e = '{default: 0};
        e.ready_ok = 1'b1;
        e.stable   = 1'b1;
        nb    = 1 << size;
        off   = int'(addr % 4);
        legal = (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
        mask  = (nb >= 8) ? -64'sd1 : ((64'sd1 <<< (8 * nb)) - 1);
        e.addr = addr - (addr % 4);
        e.we   = we;
        if (nb <= 4) begin
            e.be = 4'(((1 << nb) - 1) << off);
            pat  = longint'(wdata) & mask;
            e.wdata = 0;
            for (int k = 0; k < 4 / nb; k++) e.wdata = e.wdata | 32'(pat << (8 * nb * k));
        end
        if (!legal) begin
            e.nbus = 0; e.lat = 1; e.err = 1'b1; e.rdata = 0;
        end else if (delay < 0 || delay >= TO) begin
            e.nbus = TO; e.lat = TO + 1; e.err = 1'b1; e.rdata = 0;
        end else begin
            e.nbus = delay + 1; e.lat = delay + 2; e.err = 1'b0;
            v = (longint'(rdata) >> (8 * off)) & mask;
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            e.rdata = we ? 32'd0 : 32'(v);
        end
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.req_ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready_o);
        end
        total++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.mem_valid_o, bus.mem_we_o,
             bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got rv=%b re=%b rd=%h mv=%b mw=%b be=%b ma=%h wd=%h want all 0",
                bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.mem_valid_o, bus.mem_we_o,
                bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.req_ready_o !== 1'b1) begin
            bad++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready_o);
        end
    endtask

    task automatic test_directed;
        obs_t o;
        run_acc(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, o);
        total++;
        if (o.addr !== 32'h10 || o.be !== 4'b1111 || o.wdata !== 32'hDEADBEEF || o.we !== 1'b1) begin
            bad++; $display("FAIL sw_bus: got a=%h be=%b wd=%h we=%b want a=10 be=1111 wd=deadbeef we=1",
                o.addr, o.be, o.wdata, o.we);
        end
        total++;
        if (o.lat !== 2 || o.err !== 1'b0 || o.ready_ok !== 1'b1) begin
            bad++; $display("FAIL sw_rsp: got lat=%0d err=%b rdy=%b want lat=2 err=0 rdy=1", o.lat, o.err, o.ready_ok);
        end
        run_acc(1'b1, SZ_B, 1'b0, 32'h13, 32'h000000A5, 32'h0, 0, o);
        total++;
        if (o.addr !== 32'h10 || o.be !== 4'b1000 || o.wdata !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL sb_bus: got a=%h be=%b wd=%h want a=10 be=1000 wd=a5a5a5a5", o.addr, o.be, o.wdata);
        end
        run_acc(1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 32'h00800000, 0, o);
        total++;
        if (o.rdata !== 32'hFFFFFF80 || o.err !== 1'b0) begin
            bad++; $display("FAIL lb: got %h err=%b want ffffff80 err=0", o.rdata, o.err);
        end
        run_acc(1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 32'h00800000, 1, o);
        total++;
        if (o.rdata !== 32'h00000080) begin
            bad++; $display("FAIL lbu: got %h want 00000080", o.rdata);
        end
        run_acc(1'b0, SZ_H, 1'b0, 32'h2, 32'h0, 32'h80010000, 0, o);
        total++;
        if (o.rdata !== 32'hFFFF8001) begin
            bad++; $display("FAIL lh: got %h want ffff8001", o.rdata);
        end
        // Ready lands in the final allowed BUS cycle: must complete without error.
        run_acc(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h12345678, 3, o);
        total++;
        if (o.nbus !== 4 || o.stable !== 1'b1 || o.lat !== 5 || o.err !== 1'b0 || o.rdata !== 32'h12345678) begin
            bad++; $display("FAIL wait3: got nbus=%0d stable=%b lat=%0d err=%b rd=%h want 4 1 5 0 12345678",
                o.nbus, o.stable, o.lat, o.err, o.rdata);
        end
    endtask

    task automatic test_misaligned;
        obs_t o;
        logic [1:0]  sz [3] = '{SZ_W, SZ_D, SZ_H};
        logic [31:0] ad [3] = '{32'h6, 32'h8, 32'h5};
        for (int i = 0; i < 3; i++) begin
            run_acc(1'b0, sz[i], 1'b0, ad[i], 32'h0, 32'hFFFFFFFF, 0, o);
            total++;
            if (o.nbus !== 0 || o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
                bad++; $display("FAIL misaligned_%0d: got nbus=%0d lat=%0d err=%b rd=%h want 0 1 1 0",
                    i, o.nbus, o.lat, o.err, o.rdata);
            end
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_acc(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, -1, o);
        total++;
        if (o.nbus !== TO || o.lat !== TO + 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.stable !== 1'b1) begin
            bad++; $display("FAIL timeout: got nbus=%0d lat=%0d err=%b rd=%h want %0d %0d 1 0",
                o.nbus, o.lat, o.err, o.rdata, TO, TO + 1);
        end
    endtask

    task automatic test_back_to_back;
        obs_t        o, e;
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rdata;
        int          delay;
        for (int n = 0; n < 80; n++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom & 32'h0000FFFF;
            if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << size) - 1);
            wdata = $urandom;
            rdata = $urandom;
            delay = int'($urandom_range(0, 5)) - 1;
            run_acc(we, size, uns, addr, wdata, rdata, delay, o);
            model(we, size, uns, addr, wdata, rdata, delay, e);
            total++;
            if (o.lat !== e.lat || o.nbus !== e.nbus || o.ready_ok !== e.ready_ok) begin
                bad++; $display("FAIL rand_timing n=%0d: got lat=%0d nbus=%0d rdy=%b want lat=%0d nbus=%0d rdy=1",
                    n, o.lat, o.nbus, o.ready_ok, e.lat, e.nbus);
            end
            total++;
            if (o.err !== e.err || o.rdata !== e.rdata) begin
                bad++; $display("FAIL rand_rsp n=%0d we=%b sz=%0d a=%h: got err=%b rd=%h want err=%b rd=%h",
                    n, we, size, addr, o.err, o.rdata, e.err, e.rdata);
            end
            if (e.nbus > 0) begin
                total++;
                if ({o.addr, o.be, o.wdata, o.we, o.stable} !== {e.addr, e.be, e.wdata, e.we, e.stable}) begin
                    bad++; $display("FAIL rand_bus n=%0d: got a=%h be=%b wd=%h we=%b st=%b want a=%h be=%b wd=%h we=%b st=1",
                        n, o.addr, o.be, o.wdata, o.we, o.stable, e.addr, e.be, e.wdata, e.we);
                end
            end
        end
    endtask

    task automatic test_reset_midbus;
        obs_t o, e;
        int   rsp_seen;
        @(posedge clk); #1;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = SZ_W;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h80;
        bus.mem_ready_i    = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.mem_valid_o !== 1'b1) begin
            bad++; $display("FAIL midbus_valid: got %b want 1", bus.mem_valid_o);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.mem_valid_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL midbus_abort: got mv=%b rv=%b want 0 0", bus.mem_valid_o, bus.rsp_valid_o);
        end
        reset    = 1'b0;
        rsp_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o !== 1'b0) rsp_seen++;
        end
        total++;
        if (rsp_seen !== 0) begin
            bad++; $display("FAIL midbus_no_rsp: got %0d responses want 0", rsp_seen);
        end
        run_acc(1'b0, SZ_H, 1'b1, 32'h86, 32'h0, 32'hBEEF1234, 1, o);
        model(1'b0, SZ_H, 1'b1, 32'h86, 32'h0, 32'hBEEF1234, 1, e);
        total++;
        if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.ready_ok !== 1'b1) begin
            bad++; $display("FAIL after_reset: got lat=%0d err=%b rd=%h rdy=%b want lat=%0d err=%b rd=%h rdy=1",
                o.lat, o.err, o.rdata, o.ready_ok, e.lat, e.err, e.rdata);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.mem_ready_i    = 1'b0;
        bus.mem_rdata_i    = '0;
        test_reset;
        test_directed;
        test_misaligned;
        test_timeout;
        test_back_to_back;
        test_reset_midbus;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
